// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read RAM between two requesters,
// with an owner lock for atomic read-modify-write and an idle timeout on that lock.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [1:0]        req_lock,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_read_address,
    input  logic [DATA_W-1:0] ram_read_data,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_write_enable
);

    logic       prio_q, prio_d;
    logic       locked_q, locked_d;
    logic       owner_q, owner_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;

    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              xfer;
    logic              gnt_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [7:0]        idle_inc;

    // Grant is forced to zero during reset so no RAM access leaks out.
    always_comb begin
        gnt = 2'b00;
        if (locked_q) begin
            gnt[owner_q] = req_valid[owner_q];
        end else if (req_valid == 2'b11) begin
            gnt[prio_q] = 1'b1;
        end else begin
            gnt = req_valid;
        end
        if (!reset_n) begin
            gnt = 2'b00;
        end
    end

    assign gnt_idx   = gnt[1];
    assign xfer      = |gnt;
    assign gnt_write = req_write[gnt_idx];
    assign sel_addr  = gnt_idx ? req_addr1 : req_addr0;
    assign sel_wdata = gnt_idx ? req_wdata1 : req_wdata0;
    assign idle_inc  = idle_cnt_q + 8'd1;

    always_comb begin
        req_ready         = gnt;
        ram_write_enable  = 1'b0;
        ram_write_address = '0;
        ram_write_data    = '0;
        ram_read_address  = '0;
        if (xfer) begin
            if (gnt_write) begin
                ram_write_enable  = 1'b1;
                ram_write_address = sel_addr;
                ram_write_data    = sel_wdata;
            end else begin
                ram_read_address = sel_addr;
            end
        end
    end

    assign rsp_valid = rd_pend_q;
    assign rsp_data  = ram_read_data;

    always_comb begin
        prio_d     = prio_q;
        locked_d   = locked_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        rd_pend_d  = 2'b00;
        if (xfer) begin
            prio_d = ~gnt_idx;
            if (!gnt_write) begin
                rd_pend_d = gnt;
            end
            // While locked only the owner can transfer, so any transfer here is the owner's.
            if (req_lock[gnt_idx]) begin
                locked_d   = 1'b1;
                owner_d    = gnt_idx;
                idle_cnt_d = 8'd0;
            end else if (locked_q) begin
                locked_d   = 1'b0;
                idle_cnt_d = 8'd0;
            end
        end else if (locked_q) begin
            if (idle_inc == 8'(LOCK_TIMEOUT)) begin
                locked_d   = 1'b0;
                idle_cnt_d = 8'd0;
            end else begin
                idle_cnt_d = idle_inc;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio_q     <= 1'b0;
            locked_q   <= 1'b0;
            owner_q    <= 1'b0;
            idle_cnt_q <= 8'd0;
            rd_pend_q  <= 2'b00;
        end else begin
            prio_q     <= prio_d;
            locked_q   <= locked_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table plus hand sequences for lock timeout
// and reset mid-read; read responses are tracked through an expected-data queue.
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [7:0]  req_addr0, req_addr1, ram_read_address, ram_write_address;
    logic [31:0] req_wdata0, req_wdata1, rsp_data, ram_read_data, ram_write_data;
    logic        ram_write_enable;

    ram_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LOCK_TIMEOUT(16)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_write         (req_write),
        .req_lock          (req_lock),
        .req_addr0         (req_addr0),
        .req_addr1         (req_addr1),
        .req_wdata0        (req_wdata0),
        .req_wdata1        (req_wdata1),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .ram_read_address  (ram_read_address),
        .ram_read_data     (ram_read_data),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_write_enable  (ram_write_enable)
    );

    always #5 clock = ~clock;

    // RAM instance model: registered read, synchronous write.
    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_write_data;
        ram_read_data <= mem[ram_read_address];
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [1:0]  lock;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic        idx;
        logic [31:0] data;
    } rsp_t;

    rsp_t sb[$];
    vec_t tbl[14];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] write,
                                input logic [1:0] lock, input logic [7:0] a0,
                                input logic [7:0] a1, input logic [31:0] d0,
                                input logic [31:0] d1, input logic [1:0] exp_ready);
        vec_t v;
        v.valid = valid; v.write = write; v.lock = lock;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.exp_ready = exp_ready;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input vec_t v, input string name);
        rsp_t        e;
        logic        g;
        logic        exp_we;
        logic [7:0]  exp_wa, exp_ra;
        logic [31:0] exp_wd;
        @(posedge clock);
        #1;
        req_valid = v.valid; req_write = v.write; req_lock = v.lock;
        req_addr0 = v.a0; req_addr1 = v.a1; req_wdata0 = v.d0; req_wdata1 = v.d1;
        #3;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, ".rsp_valid"}, rsp_valid, e.idx ? 2'b10 : 2'b01);
            chk({name, ".rsp_data"}, rsp_data, e.data);
        end else begin
            chk({name, ".rsp_idle"}, rsp_valid, 2'b00);
        end
        g = v.exp_ready[1];
        exp_we = 1'b0; exp_wa = '0; exp_wd = '0; exp_ra = '0;
        if (v.exp_ready != 2'b00) begin
            if (v.write[g]) begin
                exp_we = 1'b1;
                exp_wa = g ? v.a1 : v.a0;
                exp_wd = g ? v.d1 : v.d0;
                exp_mem[exp_wa] = exp_wd;
            end else begin
                exp_ra = g ? v.a1 : v.a0;
                e.idx  = g;
                e.data = exp_mem[exp_ra];
                sb.push_back(e);
            end
        end
        chk({name, ".ready"}, req_ready, v.exp_ready);
        chk({name, ".we"}, ram_write_enable, exp_we);
        chk({name, ".waddr"}, ram_write_address, exp_wa);
        chk({name, ".wdata"}, ram_write_data, exp_wd);
        chk({name, ".raddr"}, ram_read_address, exp_ra);
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE0000 + i * 32'h101;
            exp_mem[i] = 32'hC0DE0000 + i * 32'h101;
        end
        // Round robin: both read, 0x10 / 0x20.
        for (int i = 0; i < 6; i++)
            tbl[i] = mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b10);
        tbl[6]  = mk(2'b01, 2'b01, 2'b00, 8'h01, 8'h00, 32'hAFFE1234, 0, 2'b01);
        tbl[7]  = mk(2'b01, 2'b00, 2'b00, 8'h01, 8'h00, 0, 0, 2'b01);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00);
        // Lock: r1 locked read 0x05 (prio is 1 here), then unlocking write.
        tbl[9]  = mk(2'b11, 2'b00, 2'b10, 8'h03, 8'h05, 0, 0, 2'b10);
        tbl[10] = mk(2'b01, 2'b00, 2'b00, 8'h03, 8'h05, 0, 0, 2'b00);
        tbl[11] = mk(2'b11, 2'b10, 2'b00, 8'h03, 8'h05, 0, 32'h12345678, 2'b10);
        tbl[12] = mk(2'b01, 2'b00, 2'b00, 8'h03, 8'h05, 0, 0, 2'b01);
        tbl[13] = mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00);

        reset_n = 1'b0;
        req_valid = 2'b11; req_write = 2'b00; req_lock = 2'b00;
        req_addr0 = 8'h10; req_addr1 = 8'h20; req_wdata0 = '1; req_wdata1 = '1;
        #12;
        chk("reset.ready", req_ready, 2'b00);
        chk("reset.rsp_valid", rsp_valid, 2'b00);
        chk("reset.we", ram_write_enable, 1'b0);
        chk("reset.raddr", ram_read_address, 8'h00);
        chk("reset.waddr", ram_write_address, 8'h00);
        chk("reset.wdata", ram_write_data, 32'h0);
        req_valid = 2'b00;
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) drive_cycle(tbl[i], $sformatf("vec%0d", i));

        // Lock timeout: prio is 1, so r1 wins the lock, then stays idle.
        drive_cycle(mk(2'b11, 2'b00, 2'b10, 8'h03, 8'h07, 0, 0, 2'b10), "to_lock");
        for (int k = 1; k <= 17; k++) begin
            v = mk(2'b01, 2'b00, 2'b00, 8'h03, 8'h07, 0, 0, (k <= 16) ? 2'b00 : 2'b01);
            drive_cycle(v, $sformatf("to_wait%0d", k));
        end
        drive_cycle(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00), "to_flush");

        // Reset while a read response is in flight; prio is 1 beforehand.
        drive_cycle(mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 2'b01), "rst_rd");
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid.rsp_valid", rsp_valid, 2'b00);
        chk("rst_mid.ready", req_ready, 2'b00);
        chk("rst_mid.raddr", ram_read_address, 8'h00);
        sb.delete();
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        drive_cycle(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00), "rst_after");
        drive_cycle(mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01), "rst_prio");
        drive_cycle(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00), "rst_flush");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares one 256x32 dual-port RAM (registered read, synchronous write, one-cycle read latency) between two independent masters. Each cycle it grants at most one read or write using round-robin priority, returns read data to the issuing requester, and supports a lock for atomic read-modify-write sequences with a timeout. It sits between requesters such as counters or sequencers and the RAM instance, and drives all RAM address, data and enable ports.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 32, RAM data width
- LOCK_TIMEOUT, 16, consecutive idle owner cycles before a lock is forcibly released (range 1..255)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid; index i = requester i
- req_ready  out  2  per-requester grant; transfer when valid & ready
- req_write  in  2  1 = write, 0 = read
- req_lock  in  2  keep ownership after this transfer
- req_addr0, req_addr1  in  ADDR_W  request address
- req_wdata0, req_wdata1  in  DATA_W  write data
- rsp_valid  out  2  read data valid for requester i
- rsp_data  out  DATA_W  read data, shared by both requesters
- ram_read_address  out  ADDR_W  to RAM read port
- ram_read_data  in  DATA_W  from RAM, valid the cycle after the address
- ram_write_address  out  ADDR_W  to RAM write port
- ram_write_data  out  DATA_W  to RAM write port
- ram_write_enable  out  1  RAM write strobe

## Operation
- State: prio (1 bit, requester with priority), locked (1 bit), owner (1 bit), idle_cnt (8 bits), rd_pend (2 bits, registered one-hot read issued last cycle).
- Grant (combinational):
  - If locked: only owner eligible; grant = req_valid[owner].
  - Otherwise: if both valid, grant prio; if one valid, grant it.
  - At most one bit of req_ready is set. req_ready = 0 while reset_n is low.
- Granted write: ram_write_enable = 1; ram_write_address and ram_write_data come from the granted requester in the same cycle.
- Granted read: ram_read_address = granted address; rd_pend[i] set for the next cycle.
- No grant: ram_write_enable = 0, ram_write_address = 0, ram_write_data = 0, ram_read_address = 0.
- Response: rsp_valid = rd_pend; rsp_data = ram_read_data passed straight through. There is no response backpressure.
- prio update: on every transfer, prio becomes the non-granted requester. prio is unchanged when there is no transfer.
- Lock:
  - A transfer with req_lock = 1 sets locked = 1 and owner = granted requester.
  - A transfer by owner with req_lock = 0 clears locked.
  - While locked, idle_cnt increments each cycle without an owner transfer and resets to 0 on an owner transfer.
  - When idle_cnt reaches LOCK_TIMEOUT, locked clears and idle_cnt returns to 0.
- Requesters must hold valid and all request fields stable until ready. The arbiter does not check this.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, ram_write_enable = 0.
  - All RAM address and data outputs = 0.
  - prio = 0, locked = 0, idle_cnt = 0, rd_pend = 0.
- Grant to RAM: zero latency. The RAM port is driven in the same cycle as the transfer.
- Read latency: a transfer in cycle T gives rsp_valid[i] = 1 with data in cycle T+1, for exactly 1 cycle.
- Throughput: one transfer per cycle. Back-to-back reads produce back-to-back responses.
- Write then read of the same address in consecutive cycles returns the new data. A read in the same cycle as a write is impossible because only one grant is issued per cycle.
- Lock timeout: lock transfer at cycle T, owner idle for cycles T+1..T+LOCK_TIMEOUT, so locked clears at the end of cycle T+LOCK_TIMEOUT. The other requester can be granted at cycle T+LOCK_TIMEOUT+1.
- Reset during operation (reset_n low):
  - All outputs go to reset values immediately.
  - A pending read response is discarded; no rsp_valid appears after reset is released.

## Test plan
- Reset: hold reset_n low with both req_valid = 1 → req_ready = 00, rsp_valid = 00, ram_write_enable = 0, all RAM addresses 0.
- Write/read: requester 0 writes address 0x01 with data 0xAFFE1234, then reads 0x01 in the next cycle → ram_write_enable = 1 in the first cycle; rsp_valid = 01 and rsp_data = 0xAFFE1234 one cycle after the read grant.
- Round-robin: both requesters hold reads to 0x10 and 0x20 for 6 cycles after reset → grants 0,1,0,1,0,1; rsp_valid alternates 01/10 one cycle later.
- Lock: requester 1 does a locked read of 0x05 while requester 0 is continuously valid → requester 0 is not granted until requester 1 writes 0x05 with req_lock = 0; requester 0 is granted the next cycle.
- Lock timeout: requester 1 does a locked read, then drops valid; requester 0 is valid throughout → first requester 0 grant exactly 17 cycles after the lock transfer (LOCK_TIMEOUT = 16).
- Reset during a read: grant a read in cycle T and pull reset_n low in cycle T+1 before the edge → rsp_valid = 00 immediately and no response after release; prio = 0 afterwards.
